// File: rtl/mux_nto1_pipe.sv
// N-input, WIDTH-bit registered selector mux with a valid/ready handshake.
// A one-entry skid register keeps full throughput under backpressure; flush and a sticky selector-error flag are included.
module mux_nto1_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          selector,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_error
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_INPUTS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             err_q;
    logic [WIDTH-1:0] captured;
    logic             sel_ok;
    logic             accept, emit;
    logic             load_main_new, load_main_skid, load_skid;

    // Out-of-range selectors match no input, so they capture zero.
    always_comb begin
        captured = '0;
        for (int unsigned k = 0; k < N_INPUTS; k++) begin
            if (selector == SEL_W'(k)) begin
                captured = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_ok    = ({1'b0, selector} < N_LIM);
    assign in_ready  = !reset && !flush && (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign sel_error = err_q;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main_new = 1'b1;
                        state_d       = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        load_main_new = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = TWO;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        load_main_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_main_new) begin
                main_q <= captured;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= captured;
            end
            if (accept && !sel_ok) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: a 4-input and a 3-input instance share stimulus and are
// checked against a depth-2 FIFO reference model, plus directed constant checks.
module tb_mux_nto1_pipe;

    logic         clock;
    logic         reset;
    logic [127:0] in_data;
    logic [1:0]   selector;
    logic         in_valid;
    logic         flush;
    logic         out_ready;
    logic         in_ready4, in_ready3;
    logic [31:0]  out_data4, out_data3;
    logic         out_valid4, out_valid3;
    logic         sel_error4, sel_error3;

    mux_nto1_pipe #(.WIDTH(32), .N_INPUTS(4), .SEL_W(2)) dut4 (
        .clock(clock), .reset(reset), .in_data(in_data), .selector(selector),
        .in_valid(in_valid), .in_ready(in_ready4), .flush(flush),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .sel_error(sel_error4)
    );

    mux_nto1_pipe #(.WIDTH(32), .N_INPUTS(3), .SEL_W(2)) dut3 (
        .clock(clock), .reset(reset), .in_data(in_data[95:0]), .selector(selector),
        .in_valid(in_valid), .in_ready(in_ready3), .flush(flush),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
        .sel_error(sel_error3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d4;
        logic [31:0] d3;
    } ent_t;

    ent_t q[$];
    bit   err_m;
    int   vectors;
    int   miscompares;
    int   emitted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] sel, input bit ordy, input bit fl);
        in_valid  = v;
        selector  = sel;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One clock cycle: check outputs against the model, clock, then update the model.
    task automatic step();
        ent_t e;
        bit   exp_rdy, exp_vld, acc, emt;
        int   s;
        #2;
        exp_rdy = !reset && !flush && (q.size() < 2);
        exp_vld = (q.size() > 0);
        check("in_ready4", in_ready4, exp_rdy);
        check("in_ready3", in_ready3, exp_rdy);
        check("out_valid4", out_valid4, exp_vld);
        check("out_valid3", out_valid3, exp_vld);
        if (exp_vld) begin
            check("out_data4", out_data4, q[0].d4);
            check("out_data3", out_data3, q[0].d3);
        end
        check("sel_error4", sel_error4, 0);
        check("sel_error3", sel_error3, err_m);
        acc  = in_valid && exp_rdy;
        emt  = exp_vld && out_ready;
        s    = int'(selector);
        e.d4 = in_data[s*32 +: 32];
        e.d3 = (s < 3) ? in_data[s*32 +: 32] : 32'h0;
        @(posedge clock);
        #1;
        if (emt) emitted++;
        if (flush) begin
            q.delete();
        end else begin
            if (emt) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                if (s >= 3) err_m = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid4"}, out_valid4, 0);
        check({tag, "_valid3"}, out_valid3, 0);
        check({tag, "_data4"}, out_data4, 0);
        check({tag, "_data3"}, out_data3, 0);
        check({tag, "_ready4"}, in_ready4, 0);
        check({tag, "_ready3"}, in_ready3, 0);
        check({tag, "_err3"}, sel_error3, 0);
    endtask

    initial begin
        int cyc;
        vectors     = 0;
        miscompares = 0;
        emitted     = 0;
        err_m       = 1'b0;
        reset       = 1'b0;
        in_data     = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        drive(0, 2'd0, 1, 0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset");
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        // Streaming: sel 2 then 0, full throughput.
        drive(1, 2'd2, 1, 0); step();
        check("stream_first", out_data4, 32'h33333333);
        drive(1, 2'd0, 1, 0); step();
        check("stream_second", out_data4, 32'h11111111);
        check("stream_valid", out_valid4, 1);
        drive(0, 2'd0, 1, 0); step();

        // Backpressure: push sel 1,3,0 with out_ready low.
        drive(1, 2'd1, 0, 0); step();
        drive(1, 2'd3, 0, 0); step();
        check("bp_ready_two", in_ready4, 0);
        check("bp_hold", out_data4, 32'h22222222);
        drive(1, 2'd0, 0, 0); step();
        check("bp_hold2", out_data4, 32'h22222222);
        drive(1, 2'd0, 1, 0); step();
        check("bp_second_out", out_data4, 32'h44444444);
        check("oor_data3", out_data3, 32'h0);
        check("oor_err3", sel_error3, 1);
        drive(1, 2'd0, 1, 0); step();
        check("bp_third_out", out_data4, 32'h11111111);
        drive(0, 2'd0, 1, 0); step();
        step();

        // Flush in state TWO with in_valid high.
        drive(1, 2'd2, 0, 0); step();
        drive(1, 2'd3, 0, 0); step();
        drive(1, 2'd0, 0, 1); step();
        check("flush_valid", out_valid4, 0);
        check("flush_err_kept", sel_error3, 1);
        drive(1, 2'd1, 0, 0); step();
        check("post_flush", out_data4, 32'h22222222);
        drive(0, 2'd0, 1, 0); step();
        step();

        // Asynchronous reset mid-stream while in TWO.
        drive(1, 2'd1, 0, 0); step();
        drive(1, 2'd2, 0, 0); step();
        #3 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        q.delete();
        err_m = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        drive(0, 2'd0, 1, 0); step();

        // Randomised traffic until 1000 emits, bounded.
        emitted = 0;
        cyc     = 0;
        while (emitted < 1000 && cyc < 20000) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 2));
            step();
            cyc++;
        end
        if (emitted < 1000) check("rand_budget", emitted, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector mux with a registered output stage and a valid/ready handshake.
- A one-entry skid buffer sustains full throughput under downstream backpressure.
- Replaces ad-hoc combinational 2:1 muxes on datapath paths that cross a pipeline boundary, such as writeback-source selection and forwarding selection.
- Adds synchronous flush and a sticky out-of-range-selector flag.

Parameters:
- WIDTH, 32: data width of each input and of the output.
- N_INPUTS, 4: number of selectable inputs; legal range 2..16.
- SEL_W, 2: selector width; must satisfy 2**SEL_W >= N_INPUTS.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N_INPUTS*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- selector  input  SEL_W  index of the input to capture.
- in_valid  input  1  upstream has a transfer this cycle.
- in_ready  output  1  block accepts a transfer this cycle.
- flush  input  1  synchronous discard of all buffered entries.
- out_data  output  WIDTH  selected data, registered.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts out_data.
- sel_error  output  1  sticky: an out-of-range selector was accepted.

Behaviour:
- Transfers:
  - Accept: in_valid && in_ready at a rising edge.
  - Emit: out_valid && out_ready at a rising edge.
- Capture rule: the captured value is in_data[selector*WIDTH +: WIDTH] when selector < N_INPUTS.
- Out-of-range selector: when selector >= N_INPUTS, the captured value is all zeros and sel_error sets at that edge.
- Storage:
  - main register: drives out_data and out_valid.
  - skid register: holds one extra entry.
- States: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
- Handshake signals:
  - in_ready = !reset && !flush && (state != TWO). It is combinational from state, flush and reset only, never from in_valid or out_ready.
  - out_valid = (state != EMPTY).
- Latency: an entry accepted at edge t appears on out_data after edge t, provided main was empty or emptied at t. Minimum latency is 1 cycle.
- Transitions (A = accept, E = emit):
  - EMPTY, A: main <= new; go to ONE.
  - ONE, A && E: main <= new; stay in ONE.
  - ONE, A && !E: skid <= new; go to TWO.
  - ONE, E && !A: go to EMPTY.
  - TWO, E: main <= skid; go to ONE. No accept is possible because in_ready is 0.
  - TWO, !E: hold both registers.
- Ordering: strict FIFO order. The skid entry is never bypassed by a newer one.
- out_data stability: out_data is stable while out_valid && !out_ready.
- Flush:
  - At the edge: state <= EMPTY and out_valid falls.
  - out_data keeps its last value; it is don't-care while invalid.
  - in_ready is 0 during flush, so nothing is accepted.
  - An emit in the same cycle still counts for the downstream.
- sel_error: set only by an accepted out-of-range selector, including an accept in the same cycle an error entry emits. Cleared only by reset; flush does not clear it.
- Reset (asynchronous; may arrive mid-transfer):
  - State EMPTY; out_valid 0; out_data 0; skid 0; sel_error 0; in_ready 0 while reset is high.
  - First edge after deassertion: in_ready is 1.
- No entry is ever lost or duplicated outside flush and reset.

Test Plan:
- Reset then streaming:
  - Stimulus: N_INPUTS=4, WIDTH=32; inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}; selector 2, then 0; in_valid=1; out_ready=1.
  - Required: out_data 0x33333333 one cycle after the first accept, then 0x11111111; out_valid stays continuously 1; in_ready stays 1.
- Backpressure:
  - Stimulus: hold out_ready=0 and push 3 entries (sel 1, 3, 0).
  - Required: two entries accepted and in_ready drops to 0 in state TWO; out_data holds 0x22222222. After releasing out_ready, outputs are 0x22222222 then 0x44444444 in order, and the third entry is accepted when in_ready returns to 1.
- Out-of-range selector:
  - Stimulus: N_INPUTS=3, SEL_W=2, selector=3, accepted.
  - Required: out_data=0, out_valid=1, sel_error=1. sel_error stays 1 through subsequent legal transfers and a flush; it returns to 0 only on reset.
- Flush in state TWO:
  - Stimulus: flush=1 with in_valid=1.
  - Required: in_ready=0 during flush; out_valid=0 on the next cycle; the next accept (selector 1) yields 0x22222222 with no stale skid data.
- Asynchronous reset mid-stream:
  - Stimulus: assert reset between clock edges while in TWO.
  - Required: out_valid=0, out_data=0 and in_ready=0 immediately, without waiting for a clock edge.
- Randomised backpressure:
  - Stimulus: 1000 transfers with random in_valid and out_ready, checked by a scoreboard.
  - Required: every accepted entry is emitted exactly once, in order, with the correct selected value.
